// File: rtl/dmem_pkg.sv
// Shared constants for the handshaked RV32 data memory: funct3 encodings,
// fault codes and the controller state encoding.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_RANGE    = 2'd2;
    localparam logic [1:0] FLT_FUNCT3   = 2'd3;

    // ST_CLEAR is only reachable when the power-on clear sweep is built in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads and stores: extracts and extends the
// load value, merges store data into the stored word, and flags misaligned
// and illegal funct3 encodings (the legal set differs for loads and stores).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_val,
    output logic [31:0] o_store_word,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection, extension, store merge and encoding checks
    always_comb begin
        w_sh         = {i_addr_lo, 3'b000};
        w_byte       = 8'(i_rword >> w_sh);
        w_half       = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_load_val   = '0;
        o_store_word = i_rword;
        o_misalign   = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_load_val             = {{24{w_byte[7]}}, w_byte};
                o_store_word[w_sh +: 8] = i_wdata[7:0];
            end
            F3_H: begin
                o_load_val = {{16{w_half[15]}}, w_half};
                o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
                o_misalign = i_addr_lo[0];
            end
            F3_W: begin
                o_load_val   = i_rword;
                o_store_word = i_wdata;
                o_misalign   = |i_addr_lo;
            end
            F3_BU: begin
                o_load_val = {24'b0, w_byte};
                o_illegal  = i_we;
            end
            F3_HU: begin
                o_load_val = {16'b0, w_half};
                o_misalign = i_addr_lo[0];
                o_illegal  = i_we;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// RV32 data memory with valid/ready request and response handshakes,
// configurable wait states and depth, and fault reporting.
// Optional build macro DMEM_CLEAR_EN: after reset, sweep the array to zero
// one word per cycle before accepting requests.
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [1:0]            resp_fault_code
);

    localparam int IDXW = $clog2(DEPTH_WORDS);

`ifdef DMEM_CLEAR_EN
    localparam state_t ST_AFTER_RESET = ST_CLEAR;
`else
    localparam state_t ST_AFTER_RESET = ST_IDLE;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_mem [DEPTH_WORDS];
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_fault;
    logic [1:0]            r_resp_code;
`ifdef DMEM_CLEAR_EN
    logic [IDXW-1:0]       r_sweep;
`endif

    logic                  w_accept;
    logic                  w_access;
    logic                  w_commit;
    logic                  w_out_of_range;
    logic                  w_misalign;
    logic                  w_illegal;
    logic [1:0]            w_code;
    logic [IDXW-1:0]       w_idx;
    logic [31:0]           w_rword;
    logic [31:0]           w_load_val;
    logic [31:0]           w_store_word;

    assign req_ready       = reset_n && (r_state == ST_IDLE);
    assign resp_valid      = (r_state == ST_RESP);
    assign resp_rdata      = r_resp_rdata;
    assign resp_fault      = r_resp_fault;
    assign resp_fault_code = r_resp_code;

    assign w_accept       = req_valid && req_ready;
    // The access happens on the edge that leaves WAIT for RESP.
    assign w_access       = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_idx          = r_addr[IDXW+1:2];
    assign w_rword        = r_mem[w_idx];
    // Upper address bits are checked rather than aliased into the array.
    assign w_out_of_range = (r_addr >> (IDXW + 2)) != '0;
    assign w_commit       = w_access && r_we && (w_code == FLT_NONE);

    dmem_lane_align u_lane_align (
        .i_we         (r_we),
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_rword      (w_rword),
        .i_wdata      (r_wdata),
        .o_load_val   (w_load_val),
        .o_store_word (w_store_word),
        .o_misalign   (w_misalign),
        .o_illegal    (w_illegal)
    );

    // Fault priority: illegal funct3, then misalignment, then range
    always_comb begin
        w_code = FLT_NONE;
        if (w_illegal)           w_code = FLT_FUNCT3;
        else if (w_misalign)     w_code = FLT_MISALIGN;
        else if (w_out_of_range) w_code = FLT_RANGE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_AFTER_RESET;
        else          r_state <= w_next;
    end

    // Next-state logic; every request passes through WAIT so the latched
    // request gets one cycle before the access even with zero wait states
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)   w_next = ST_WAIT;
            ST_WAIT: if (w_access)   w_next = ST_RESP;
            ST_RESP: if (resp_ready) w_next = ST_IDLE;
`ifdef DMEM_CLEAR_EN
            ST_CLEAR: if (r_sweep == IDXW'(DEPTH_WORDS - 1)) w_next = ST_IDLE;
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    // Wait-state counter, loaded at acceptance and counted down in WAIT
    always_ff @(posedge clk) begin
        if (!reset_n)                             r_cnt <= 4'd0;
        else if (w_accept)                        r_cnt <= 4'(WAIT_STATES);
        else if (r_state == ST_WAIT && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
    end

    // Request capture at acceptance
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // Array writes: clear sweep or committed store; reset suppresses both
    always_ff @(posedge clk) begin
        if (reset_n) begin
`ifdef DMEM_CLEAR_EN
            if (r_state == ST_CLEAR) r_mem[r_sweep] <= '0;
`endif
            if (w_commit) r_mem[w_idx] <= w_store_word;
        end
    end

    // Response registers, held stable through RESP
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
            r_resp_code  <= FLT_NONE;
        end else if (w_access) begin
            r_resp_rdata <= (!r_we && w_code == FLT_NONE) ? w_load_val : 32'd0;
            r_resp_fault <= (w_code != FLT_NONE);
            r_resp_code  <= w_code;
        end
    end

`ifdef DMEM_CLEAR_EN
    // Clear sweep address; restarts from zero on every reset
    always_ff @(posedge clk) begin
        if (!reset_n)                 r_sweep <= '0;
        else if (r_state == ST_CLEAR) r_sweep <= r_sweep + IDXW'(1);
    end
`endif

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed plus randomized bench for data_memory_hs (WAIT_STATES=2,
// DEPTH_WORDS=1024), checked against a behavioural memory model.
module tb_data_memory_hs;

    localparam int AW = 32;
    localparam int DW = 1024;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_fault_code;

    int errors = 0;
    int checks = 0;
    logic [31:0] mm [DW];

    always #5 clk = ~clk;

    data_memory_hs #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .resp_fault_code(resp_fault_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour computed from the access rules with plain arithmetic
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic flt, output logic [1:0] code);
        int size, sh;
        logic [31:0] word, mask, v;
        bit illegal, mis, oor;
        illegal = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        mis  = (size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0);
        oor  = addr >= DW * 4;
        code = illegal ? 2'd3 : mis ? 2'd1 : oor ? 2'd2 : 2'd0;
        flt  = (code != 2'd0);
        rd   = 32'd0;
        if (flt) return;
        sh   = 8 * (addr % 4);
        word = mm[addr / 4];
        if (we) begin
            if (size == 4) mm[addr / 4] = wd;
            else begin
                mask = (size == 1 ? 32'hFF : 32'hFFFF) << sh;
                mm[addr / 4] = (word & ~mask) | ((wd << sh) & mask);
            end
        end else begin
            v = word >> sh;
            if (size == 4) rd = word;
            else if (size == 1) rd = (f3 == 3'd0 && v[7])  ? (v | 32'hFFFFFF00) : (v & 32'hFF);
            else                rd = (f3 == 3'd1 && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
        end
    endfunction

    // One full transaction; called #1 after a rising edge with the DUT idle
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall, output logic [31:0] ord,
                          output logic of, output logic [1:0] oc);
        logic [31:0] er;
        logic ef;
        logic [1:0] ec;
        int cyc;
        model(we, f3, addr, wd, er, ef, ec);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        cyc = 0;
        while (!resp_valid && cyc < 40) begin
            check("req_ready_busy", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(1 + WS));
        ord = resp_rdata; of = resp_fault; oc = resp_fault_code;
        if (!resp_valid) return;
        check("rdata", resp_rdata, er);
        check("fault", 32'(resp_fault), 32'(ef));
        check("fault_code", 32'(resp_fault_code), 32'(ec));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_rdata", resp_rdata, er);
            check("stall_code", 32'(resp_fault_code), 32'(ec));
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_drop", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, wd, addr;
        logic f;
        logic [1:0] c;
        int r;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        check("rst_code", 32'(resp_fault_code), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Fill a 16-word window so every later load reads known data
        for (int i = 0; i < 16; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd, f, c);

        // Directed accesses
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, f, c);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, f, c);
        check("lw_deadbeef", rd, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 32'h13, 32'h00000080, 0, rd, f, c);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 0, rd, f, c);
        check("lb_sext", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, 0, rd, f, c);
        check("lbu_zext", rd, 32'h00000080);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, f, c);
        check("lw_merged", rd, 32'h80ADBEEF);
        do_req(1'b0, 3'd1, 32'h11, 32'h0, 0, rd, f, c);
        check("lh_mis_code", 32'(c), 32'd1);
        check("lh_mis_rdata", rd, 32'd0);
        do_req(1'b1, 3'd2, 32'h11, 32'h11111111, 0, rd, f, c);
        check("sw_mis_code", 32'(c), 32'd1);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, f, c);
        check("lw_after_fault", rd, 32'h80ADBEEF);
        do_req(1'b0, 3'd2, 32'h1000, 32'h0, 0, rd, f, c);
        check("lw_range_code", 32'(c), 32'd2);
        do_req(1'b0, 3'd3, 32'h11, 32'h0, 0, rd, f, c);
        check("f3_illegal_code", 32'(c), 32'd3);
        do_req(1'b1, 3'd1, 32'h16, 32'h0000A55A, 0, rd, f, c);
        do_req(1'b0, 3'd5, 32'h16, 32'h0, 0, rd, f, c);
        check("lhu_upper", rd, 32'h0000A55A);

        // Response held for 5 cycles
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, f, c);

        // Reset during WAIT of a store aborts it
        check("abort_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort_rdata", resp_rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_resp", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, f, c);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'h1000 + $urandom_range(0, 255);
            else if (r == 1) addr = $urandom | 32'h8000_0000;
            else             addr = $urandom_range(0, 63);
            wd = $urandom;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, wd,
                   $urandom_range(0, 3), rd, f, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
